// File: rtl/riscv_sim_pkg.sv
// ============================================================================
// Module   : riscv_sim_pkg
// Purpose  : Shared encodings for the RISCV simulation run-control monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_sim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] ST_PASS   = 32'd1;
  localparam int          MAX_LANES = 8;

endpackage : riscv_sim_pkg

`default_nettype wire

// File: rtl/riscv_sim_popcount.sv
// ============================================================================
// Module   : riscv_sim_popcount
// Purpose  : Combinational count of set bits across the retire-lane strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_sim_popcount
  import riscv_sim_pkg::*;
#(
  parameter  int p_lanes = 2,
  localparam int c_out_w = $clog2(p_lanes + 1)
) (
  input  logic [p_lanes-1:0] bits,
  output logic [c_out_w-1:0] count
);

  if ((p_lanes < 1) || (p_lanes > MAX_LANES)) begin : g_bad_lanes
    $error("riscv_sim_popcount: p_lanes out of range");
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < p_lanes; i++) begin
      count = count + c_out_w'(bits[i]);
    end
  end

endmodule : riscv_sim_popcount

`default_nettype wire

// File: rtl/riscv_sim_multilane_monitor.sv
// ============================================================================
// Module   : riscv_sim_multilane_monitor
// Purpose  : Run-control and statistics monitor for the multi-issue RISCV
//            simulation harness (cycle/retire counters, pass/fail/timeout).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_sim_multilane_monitor
  import riscv_sim_pkg::*;
#(
  parameter int p_lanes        = 2,
  parameter int p_cnt_sz       = 32,
  parameter int p_drain_cycles = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stats_en,
  input  logic [p_cnt_sz-1:0] max_cycles,
  input  logic [p_lanes-1:0]  inst_val,
  input  logic [31:0]         status,
  output logic [p_cnt_sz-1:0] num_cycles,
  output logic [p_cnt_sz-1:0] num_inst,
  output logic [1:0]          state,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic                timeout,
  output logic [31:0]         fail_code
);

  localparam int c_pop_w   = $clog2(p_lanes + 1);
  localparam int c_drain_w = (p_drain_cycles > 1) ? $clog2(p_drain_cycles) : 1;
  localparam logic [c_drain_w-1:0] c_drain_init = c_drain_w'(p_drain_cycles - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [p_cnt_sz-1:0]   r_cycle_count;
  logic [p_cnt_sz-1:0]   r_num_cycles;
  logic [p_cnt_sz-1:0]   r_num_inst;
  logic [c_drain_w-1:0]  r_drain_cnt;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_fail;
  logic                  r_timeout;
  logic [31:0]           r_fail_code;

  logic [c_pop_w-1:0]    w_pop;
  logic                  w_status_pass;
  logic                  w_status_fail;
  logic                  w_over_budget;
  logic                  w_detect;
  logic                  w_count;
  logic                  w_drain_last;
  logic [p_cnt_sz:0]     w_cc_sum;
  logic [p_cnt_sz:0]     w_nc_sum;
  logic [p_cnt_sz:0]     w_ni_sum;
  logic [p_cnt_sz-1:0]   w_cc_next;
  logic [p_cnt_sz-1:0]   w_nc_next;
  logic [p_cnt_sz-1:0]   w_ni_next;

  riscv_sim_popcount #(
    .p_lanes (p_lanes)
  ) u_popcount (
    .bits  (inst_val),
    .count (w_pop)
  );

  assign w_status_pass = (status == ST_PASS);
  assign w_status_fail = (status > ST_PASS);
  assign w_over_budget = (r_cycle_count > max_cycles);
  assign w_detect      = (r_state == RUN) && ((status != 32'd0) || w_over_budget);
  assign w_count       = (r_state == RUN) && !w_detect;
  assign w_drain_last  = (r_state == DRAIN) && (r_drain_cnt == '0);

  // Widen by one bit so a carry out signals saturation instead of wrapping.
  assign w_cc_sum  = {1'b0, r_cycle_count} + (p_cnt_sz + 1)'(1);
  assign w_nc_sum  = {1'b0, r_num_cycles}  + (p_cnt_sz + 1)'(1);
  assign w_ni_sum  = {1'b0, r_num_inst}    + (p_cnt_sz + 1)'(w_pop);
  assign w_cc_next = w_cc_sum[p_cnt_sz] ? '1 : w_cc_sum[p_cnt_sz-1:0];
  assign w_nc_next = w_nc_sum[p_cnt_sz] ? '1 : w_nc_sum[p_cnt_sz-1:0];
  assign w_ni_next = w_ni_sum[p_cnt_sz] ? '1 : w_ni_sum[p_cnt_sz-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = RUN;
      RUN:     if (w_detect) w_state_next = DRAIN;
      DRAIN:   if (w_drain_last) w_state_next = DONE;
      DONE:    w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle_count <= '0;
      r_num_cycles  <= '0;
      r_num_inst    <= '0;
      r_drain_cnt   <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
      r_fail_code   <= '0;
    end else begin
      if (w_count) begin
        r_cycle_count <= w_cc_next;
        if (stats_en) begin
          r_num_cycles <= w_nc_next;
          r_num_inst   <= w_ni_next;
        end
      end

      // A nonzero status outranks a timeout raised in the same cycle.
      if (w_detect) begin
        r_drain_cnt <= c_drain_init;
        if (w_status_pass) begin
          r_pass <= 1'b1;
        end else if (w_status_fail) begin
          r_fail      <= 1'b1;
          r_fail_code <= status;
        end else begin
          r_fail      <= 1'b1;
          r_timeout   <= 1'b1;
          r_fail_code <= '0;
        end
      end else if ((r_state == DRAIN) && !w_drain_last) begin
        r_drain_cnt <= r_drain_cnt - c_drain_w'(1);
      end

      if (w_drain_last) begin
        r_done <= 1'b1;
      end
    end
  end

  assign state      = r_state;
  assign num_cycles = r_num_cycles;
  assign num_inst   = r_num_inst;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign timeout    = r_timeout;
  assign fail_code  = r_fail_code;

endmodule : riscv_sim_multilane_monitor

`default_nettype wire
